// File: rtl/psx_multitap_poller.sv
// Round-robin PlayStation controller poller: NUM_PADS pads share psx_clk/cmd/data/ack, each with its own att line.
// Define PSX_ANALOG_EN to extend 0x73 (analog) replies to 9 bytes and publish stick_state.
module psx_multitap_poller #(
  parameter int unsigned NUM_PADS      = 2,
  parameter int unsigned BOOT_TIME     = 100000,
  parameter int unsigned HALF_BIT      = 5,
  parameter int unsigned ACK_TIMEOUT   = 100,
  parameter int unsigned BYTE_GAP      = 10,
  parameter int unsigned POLL_INTERVAL = 32000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data,
  input  logic                   ack,
  output logic                   psx_clk,
  output logic                   cmd,
  output logic [NUM_PADS-1:0]    att,
  output logic [16*NUM_PADS-1:0] button_state,
  output logic [NUM_PADS-1:0]    pad_present,
  output logic                   frame_done
`ifdef PSX_ANALOG_EN
  ,
  output logic [32*NUM_PADS-1:0] stick_state
`endif
);

  localparam int unsigned PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
`ifdef PSX_ANALOG_EN
  localparam int unsigned NB = 9;
`else
  localparam int unsigned NB = 5;
`endif

  typedef enum logic [3:0] {
    S_BOOT, S_SELECT, S_SHIFT, S_WAIT_ACK, S_GAP,
    S_RELEASE, S_ABORT, S_NEXT, S_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [PW-1:0]           pad_q, pad_d;
  logic [3:0]              byte_q, byte_d;
  logic [2:0]              bit_q, bit_d;
  logic                    high_q, high_d;
  logic [7:0]              sh_q, sh_d;
  logic [NB-1:1][7:0]      rx_q, rx_d;
  logic [1:0]              data_sync_q, ack_sync_q;
  logic [NUM_PADS-1:0]     att_q, att_d;
  logic                    psx_clk_q, psx_clk_d;
  logic                    cmd_q, cmd_d;
  logic [16*NUM_PADS-1:0]  button_q, button_d;
  logic [NUM_PADS-1:0]     present_q, present_d;
  logic                    frame_done_q, frame_done_d;
`ifdef PSX_ANALOG_EN
  logic [32*NUM_PADS-1:0]  stick_q, stick_d;
`endif

  logic       data_s, ack_s;
  logic       last_byte, reply_ok;
  logic       start_select, start_byte;
  logic [7:0] cbyte;

  assign data_s = data_sync_q[1];
  assign ack_s  = ack_sync_q[1];

  assign reply_ok = ((rx_q[1][7:4] == 4'h4) || (rx_q[1][7:4] == 4'h7)) && (rx_q[2] == 8'h5A);

`ifdef PSX_ANALOG_EN
  assign last_byte = (byte_q == 4'd8) || ((byte_q == 4'd4) && (rx_q[1] != 8'h73));
`else
  assign last_byte = (byte_q == 4'd4);
  logic unused_id_low;
  assign unused_id_low = ^rx_q[1][3:0];
`endif

  function automatic logic [7:0] cmd_byte(input logic [3:0] n);
    case (n)
      4'd0:    return 8'h01;
      4'd1:    return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    pad_d        = pad_q;
    byte_d       = byte_q;
    bit_d        = bit_q;
    high_d       = high_q;
    sh_d         = sh_q;
    rx_d         = rx_q;
    att_d        = att_q;
    psx_clk_d    = psx_clk_q;
    cmd_d        = cmd_q;
    button_d     = button_q;
    present_d    = present_q;
    frame_done_d = 1'b0;
`ifdef PSX_ANALOG_EN
    stick_d      = stick_q;
`endif
    start_select = 1'b0;
    start_byte   = 1'b0;
    cbyte        = 8'h00;

    case (state_q)
      S_BOOT:
        if (cnt_q == 32'(BOOT_TIME - 1)) begin
          pad_d        = '0;
          start_select = 1'b1;
        end
      S_SELECT:
        if (cnt_q == 32'(2 * HALF_BIT - 1)) begin
          byte_d     = '0;
          start_byte = 1'b1;
        end
      S_SHIFT:
        if (cnt_q == 32'(HALF_BIT - 1)) begin
          cnt_d = '0;
          if (!high_q) begin
            high_d    = 1'b1;
            psx_clk_d = 1'b1;
            sh_d      = {data_s, sh_q[7:1]};
          end else if (bit_q == 3'd7) begin
            // byte 0 of the reply carries nothing useful, so it is not stored
            for (int unsigned i = 1; i < NB; i++)
              if (byte_q == 4'(i)) rx_d[i] = sh_q;
            state_d = last_byte ? S_RELEASE : S_WAIT_ACK;
          end else begin
            bit_d     = bit_q + 3'd1;
            high_d    = 1'b0;
            psx_clk_d = 1'b0;
            cbyte     = cmd_byte(byte_q);
            cmd_d     = cbyte[bit_d];
          end
        end
      S_WAIT_ACK:
        if (!ack_s) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == 32'(ACK_TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end
      S_GAP:
        if (cnt_q == 32'(BYTE_GAP - 1)) begin
          byte_d     = byte_q + 4'd1;
          start_byte = 1'b1;
        end
      S_RELEASE:
        if (cnt_q == '0) begin
          if (reply_ok) begin
            for (int unsigned i = 0; i < NUM_PADS; i++)
              if (pad_q == PW'(i)) begin
                button_d[16*i +: 16] = {rx_q[4], rx_q[3]};
                present_d[i]         = 1'b1;
`ifdef PSX_ANALOG_EN
                stick_d[32*i +: 32]  = (rx_q[1] == 8'h73) ?
                                       {rx_q[8], rx_q[7], rx_q[6], rx_q[5]} : 32'h80808080;
`endif
              end
            att_d = '1;
            cmd_d = 1'b1;
          end else begin
            state_d = S_ABORT;
          end
        end else if (cnt_q == 32'(2 * HALF_BIT - 1)) begin
          state_d = S_NEXT;
        end
      S_ABORT: begin
        for (int unsigned i = 0; i < NUM_PADS; i++)
          if (pad_q == PW'(i)) begin
            button_d[16*i +: 16] = 16'hFFFF;
            present_d[i]         = 1'b0;
`ifdef PSX_ANALOG_EN
            stick_d[32*i +: 32]  = 32'h80808080;
`endif
          end
        att_d   = '1;
        cmd_d   = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT:
        if (pad_q == PW'(NUM_PADS - 1)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
          cnt_d        = '0;
        end else begin
          pad_d        = pad_q + PW'(1);
          start_select = 1'b1;
        end
      S_IDLE:
        if (cnt_q == 32'(POLL_INTERVAL - 1)) begin
          pad_d        = '0;
          start_select = 1'b1;
        end
      default: state_d = S_BOOT;
    endcase

    if (start_select) begin
      state_d = S_SELECT;
      cnt_d   = '0;
      att_d   = '1;
      for (int unsigned i = 0; i < NUM_PADS; i++)
        if (pad_d == PW'(i)) att_d[i] = 1'b0;
    end

    // psx_clk falls and the first cmd bit appears on the same edge
    if (start_byte) begin
      state_d   = S_SHIFT;
      cnt_d     = '0;
      bit_d     = '0;
      high_d    = 1'b0;
      psx_clk_d = 1'b0;
      cbyte     = cmd_byte(byte_d);
      cmd_d     = cbyte[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      cnt_q        <= '0;
      pad_q        <= '0;
      byte_q       <= '0;
      bit_q        <= '0;
      high_q       <= 1'b0;
      sh_q         <= '0;
      rx_q         <= '0;
      data_sync_q  <= '1;
      ack_sync_q   <= '1;
      att_q        <= '1;
      psx_clk_q    <= 1'b1;
      cmd_q        <= 1'b1;
      button_q     <= '1;
      present_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef PSX_ANALOG_EN
      stick_q      <= {NUM_PADS{32'h80808080}};
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pad_q        <= pad_d;
      byte_q       <= byte_d;
      bit_q        <= bit_d;
      high_q       <= high_d;
      sh_q         <= sh_d;
      rx_q         <= rx_d;
      data_sync_q  <= {data_sync_q[0], data};
      ack_sync_q   <= {ack_sync_q[0], ack};
      att_q        <= att_d;
      psx_clk_q    <= psx_clk_d;
      cmd_q        <= cmd_d;
      button_q     <= button_d;
      present_q    <= present_d;
      frame_done_q <= frame_done_d;
`ifdef PSX_ANALOG_EN
      stick_q      <= stick_d;
`endif
    end
  end

  assign att          = att_q;
  assign psx_clk      = psx_clk_q;
  assign cmd          = cmd_q;
  assign button_state = button_q;
  assign pad_present  = present_q;
  assign frame_done   = frame_done_q;
`ifdef PSX_ANALOG_EN
  assign stick_state  = stick_q;
`endif

endmodule
